regfile_shadow: RTL and testbench
=================================

Name: regfile_shadow

Overview:
- Dual-bank MIPS general-purpose register file, directly downstream of the register-index adapter.
- Consumes read indices IR1/IR2 and write index W; supplies operands R1/R2 to the execute stage.
- Bank 0 is the normal context. Bank 1 is a shadow context used while servicing an interrupt, so the handler does not have to spill GPRs.
- Also exposes a debug read port for the board display.

Parameters:
- DATA_BITS, 32, width of each register.
- REG_COUNT, 32, registers per bank; index width is fixed at 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IR1  in  5  read port 1 index (rs).
- IR2  in  5  read port 2 index (rt).
- W  in  5  write index (rd / rt / 31 for jal).
- WE  in  1  write enable.
- Din  in  DATA_BITS  write data.
- int_enter  in  1  single-cycle pulse: switch to shadow bank.
- int_exit  in  1  single-cycle pulse (eret): switch to normal bank.
- R1  out  DATA_BITS  read data, port 1.
- R2  out  DATA_BITS  read data, port 2.
- bank  out  1  active bank (0 normal, 1 shadow); registered.
- nest_err  out  1  sticky flag: int_enter seen while bank=1.
- dbg_idx  in  5  debug read index.
- dbg_data  out  DATA_BITS  debug read data, always from bank 0, no bypass.

Behaviour:
- Reset (rst_n=0, async):
  - All 2x32 registers cleared to 0.
  - bank=0, nest_err=0.
  - R1, R2 and dbg_data therefore read 0 while reset is held.
- Reads are combinational and come from the active bank, indexed by IR1/IR2.
- Register 0 reads 0 in both banks, always, regardless of writes or bypass.
- Writes are synchronous:
  - On a rising edge with WE=1 and W!=0, Din is stored to register W of the bank active before that edge.
  - W=0 writes are discarded.
- Write-through bypass:
  - If WE=1, W!=0 and IR1==W, then R1=Din in the same cycle. R2 behaves the same way with IR2.
  - This gives zero-latency read-after-write for same-cycle WB/ID overlap.
- Bank state machine, two states:
  - NORMAL (bank=0): int_enter=1 at the edge moves to SHADOW. int_exit is ignored.
  - SHADOW (bank=1): int_exit=1 at the edge moves to NORMAL. int_enter=1 keeps SHADOW and sets nest_err=1.
  - nest_err clears only on reset.
  - int_enter and int_exit both high in NORMAL: go to SHADOW (enter has priority).
  - int_enter and int_exit both high in SHADOW: go to NORMAL and also set nest_err.
- Simultaneous write and bank switch:
  - The write targets the old bank.
  - The bypass in that cycle also reflects the old bank.
  - From the next cycle, reads come from the new bank.
- Shadow bank contents persist across enter/exit. They are not cleared on entry.
- Bank 1 is only reachable through int_enter. dbg_data ignores bank so the display is stable during handlers.
- Reset asserted mid-handler: returns immediately to NORMAL with both banks zeroed.
- No X propagation: every index value 0..31 is legal on all ports.

Test Plan:
- Reset then read: hold rst_n=0, then release. IR1=5, IR2=31 → R1=0, R2=0, bank=0, nest_err=0.
- Write/read and $zero:
  - WE=1, W=8, Din=0xDEADBEEF for one edge, then IR1=8 → R1=0xDEADBEEF.
  - WE=1, W=0, Din=0x1234, then IR2=0 → R2=0.
- Bypass: same cycle WE=1, W=3, Din=0xA5A5A5A5, IR1=3, IR2=3 → R1=R2=0xA5A5A5A5 before the edge. After the edge, with WE=0, both still read 0xA5A5A5A5.
- Shadow isolation:
  - Write bank0 r9=0x11. Pulse int_enter, then bank=1 and IR1=9 → R1=0.
  - Write r9=0x22 in shadow, then pulse int_exit. Now bank=0 and R1=0x11; dbg_idx=9 → dbg_data=0x11.
  - Re-enter: R1=0x22 (the shadow value persisted).
- Switch-edge write: in NORMAL, assert int_enter together with WE=1, W=4, Din=0x77 → bank0 r4=0x77, shadow r4=0. Check after exit, and via dbg_idx=4.
- Nesting and async reset:
  - In SHADOW, pulse int_enter → bank stays 1, nest_err=1.
  - Pull rst_n low mid-cycle → bank=0, nest_err=0 and all registers read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_shadow.sv
// Dual-bank MIPS GPR file: bank 0 is the normal context, bank 1 a shadow
// context for interrupt handlers. Combinational reads with write-through bypass.
module regfile_shadow #(
    parameter int DATA_BITS = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           IR1,
    input  logic [4:0]           IR2,
    input  logic [4:0]           W,
    input  logic                 WE,
    input  logic [DATA_BITS-1:0] Din,
    input  logic                 int_enter,
    input  logic                 int_exit,
    output logic [DATA_BITS-1:0] R1,
    output logic [DATA_BITS-1:0] R2,
    output logic                 bank,
    output logic                 nest_err,
    input  logic [4:0]           dbg_idx,
    output logic [DATA_BITS-1:0] dbg_data
);

    localparam logic NORMAL = 1'b0;
    localparam logic SHADOW = 1'b1;

    logic [DATA_BITS-1:0] mem_q [2][REG_COUNT];
    logic [DATA_BITS-1:0] mem_d [2][REG_COUNT];
    logic                 bank_q, bank_d;
    logic                 nest_err_q, nest_err_d;
    logic                 wr_valid;

    assign wr_valid = WE && (W != 5'd0);

    // The write always lands in the bank that was active before the edge,
    // even when the same edge switches banks.
    always_comb begin
        mem_d = mem_q;
        if (wr_valid) begin
            mem_d[bank_q][W] = Din;
        end
    end

    always_comb begin
        bank_d     = bank_q;
        nest_err_d = nest_err_q;
        case (bank_q)
            NORMAL: begin
                if (int_enter) begin
                    bank_d = SHADOW;
                end
            end
            SHADOW: begin
                if (int_enter) begin
                    nest_err_d = 1'b1;
                end
                if (int_exit) begin
                    bank_d = NORMAL;
                end
            end
            default: bank_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            bank_q     <= NORMAL;
            nest_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            bank_q     <= bank_d;
            nest_err_q <= nest_err_d;
        end
    end

    // Register 0 is hard-wired to zero and never bypassed; outputs are forced
    // to zero while reset is held so a pending write cannot leak through.
    always_comb begin
        R1 = '0;
        R2 = '0;
        if (rst_n) begin
            if (IR1 != 5'd0) begin
                R1 = (wr_valid && (IR1 == W)) ? Din : mem_q[bank_q][IR1];
            end
            if (IR2 != 5'd0) begin
                R2 = (wr_valid && (IR2 == W)) ? Din : mem_q[bank_q][IR2];
            end
        end
    end

    assign dbg_data = rst_n ? mem_q[0][dbg_idx] : '0;
    assign bank     = bank_q;
    assign nest_err = nest_err_q;

endmodule

// File: tb/tb_regfile_shadow.sv
// Self-checking bench for regfile_shadow: per-cycle comparison against a
// behavioural two-bank model plus directed literal checks.
module tb_regfile_shadow;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IR1, IR2, W, dbg_idx;
    logic        WE, int_enter, int_exit;
    logic [31:0] Din;
    logic [31:0] R1, R2, dbg_data;
    logic        bank, nest_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_regs [2][32];
    logic        model_bank;
    logic        model_nest;

    regfile_shadow #(.DATA_BITS(32), .REG_COUNT(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IR1       (IR1),
        .IR2       (IR2),
        .W         (W),
        .WE        (WE),
        .Din       (Din),
        .int_enter (int_enter),
        .int_exit  (int_exit),
        .R1        (R1),
        .R2        (R2),
        .bank      (bank),
        .nest_err  (nest_err),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: per-bank register arrays, an active-bank bit and
    // a sticky nesting flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 32; i++) begin
                    model_regs[b][i] <= 32'd0;
                end
            end
            model_bank <= 1'b0;
            model_nest <= 1'b0;
        end else begin
            if (WE && W != 5'd0) begin
                model_regs[model_bank][W] <= Din;
            end
            if (model_bank && int_enter) begin
                model_nest <= 1'b1;
            end
            if (model_bank == 1'b0) begin
                model_bank <= int_enter;
            end else begin
                model_bank <= !int_exit;
            end
        end
    end

    function automatic logic [31:0] expected_read(input logic [4:0] idx);
        if (!rst_n || idx == 5'd0) begin
            return 32'd0;
        end
        if (WE && W != 5'd0 && idx == W) begin
            return Din;
        end
        return model_regs[model_bank][idx];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check_output("cyc_R1", R1, expected_read(IR1));
        check_output("cyc_R2", R2, expected_read(IR2));
        check_output("cyc_bank", {31'd0, bank}, {31'd0, model_bank});
        check_output("cyc_nest", {31'd0, nest_err}, {31'd0, model_nest});
        check_output("cyc_dbg", dbg_data, rst_n ? model_regs[0][dbg_idx] : 32'd0);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] ir1, input logic [4:0] ir2, input logic we,
                                  input logic [4:0] w, input logic [31:0] din,
                                  input logic ent, input logic ext);
        IR1       = ir1;
        IR2       = ir2;
        WE        = we;
        W         = w;
        Din       = din;
        int_enter = ent;
        int_exit  = ext;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dbg_idx = 5'd0;
        apply_stimulus(5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        check_output("reset_R1", R1, 32'd0);
        check_output("reset_R2", R2, 32'd0);
        check_output("reset_bank", {31'd0, bank}, 32'd0);
        check_output("reset_nest", {31'd0, nest_err}, 32'd0);

        apply_stimulus(5'd0, 5'd0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle();
        apply_stimulus(5'd8, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("write_r8", R1, 32'hDEADBEEF);

        apply_stimulus(5'd8, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        check_output("zero_nobypass", R2, 32'd0);
        cycle();
        apply_stimulus(5'd8, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("zero_after", R2, 32'd0);

        apply_stimulus(5'd3, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
        check_output("bypass_R1", R1, 32'hA5A5A5A5);
        check_output("bypass_R2", R2, 32'hA5A5A5A5);
        cycle();
        apply_stimulus(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("stored_R1", R1, 32'hA5A5A5A5);
        check_output("stored_R2", R2, 32'hA5A5A5A5);

        apply_stimulus(5'd9, 5'd0, 1'b1, 5'd9, 32'h11, 1'b0, 1'b0);
        cycle();
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle();
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("shadow_bank", {31'd0, bank}, 32'd1);
        check_output("shadow_r9_empty", R1, 32'd0);
        apply_stimulus(5'd9, 5'd0, 1'b1, 5'd9, 32'h22, 1'b0, 1'b0);
        cycle();
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle();
        dbg_idx = 5'd9;
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("exit_bank", {31'd0, bank}, 32'd0);
        check_output("normal_r9", R1, 32'h11);
        check_output("dbg_r9", dbg_data, 32'h11);
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle();
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("persist_r9", R1, 32'h22);
        check_output("dbg_in_shadow", dbg_data, 32'h11);
        apply_stimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle();

        // Write on the same edge as entering the shadow bank.
        apply_stimulus(5'd4, 5'd0, 1'b1, 5'd4, 32'h77, 1'b1, 1'b0);
        check_output("switch_bypass", R1, 32'h77);
        cycle();
        dbg_idx = 5'd4;
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("switch_bank", {31'd0, bank}, 32'd1);
        check_output("shadow_r4", R1, 32'd0);
        check_output("dbg_r4", dbg_data, 32'h77);
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle();
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("normal_r4", R1, 32'h77);

        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cycle();
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("both_normal_bank", {31'd0, bank}, 32'd1);
        check_output("both_normal_nest", {31'd0, nest_err}, 32'd0);
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle();
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("nest_bank", {31'd0, bank}, 32'd1);
        check_output("nest_flag", {31'd0, nest_err}, 32'd1);
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cycle();
        apply_stimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("both_shadow_bank", {31'd0, bank}, 32'd0);
        check_output("nest_sticky", {31'd0, nest_err}, 32'd1);

        apply_stimulus(5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle();
        dbg_idx = 5'd8;
        apply_stimulus(5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("pre_reset_r9", R1, 32'h22);
        check_output("pre_reset_dbg", dbg_data, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_bank", {31'd0, bank}, 32'd0);
        check_output("async_nest", {31'd0, nest_err}, 32'd0);
        check_output("async_R1", R1, 32'd0);
        check_output("async_dbg", dbg_data, 32'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        check_output("cleared_r3", R2, 32'd0);
        check_output("cleared_r9", R1, 32'd0);

        apply_stimulus(5'd31, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 1'b0);
        cycle();
        apply_stimulus(5'd31, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_output("r31", R1, 32'hCAFEF00D);
        check_output("r8_cleared", R2, 32'd0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
